alu_op_sequencer: RTL and testbench



---
 rtl/alu_op_sequencer.sv | 134 +++++++++++++
 tb/tb_alu_op_sequencer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// Issues one ALU op at a time: maps op codes to Fxn selects, waits ALU_LAT cycles, returns the result.
// Optional result self-check enabled by macro ALU_SEQ_CHECK_EN (adds chk_mismatch output).
module alu_op_sequencer #(
    parameter int DW      = 6,
    parameter int ALU_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [DW-1:0] cmd_a,
    input  logic [DW-1:0] cmd_b,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [2:0]    alu_fxn,
    input  logic [DW-1:0] alu_result,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_err
`ifdef ALU_SEQ_CHECK_EN
    ,
    output logic          chk_mismatch
`endif
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t        state, stateNext;
    logic [3:0]    latCnt, latCntNext;
    logic [DW-1:0] aluANext, aluBNext, rspDataNext;
    logic [2:0]    aluFxnNext;
    logic          rspErrNext;
    logic          capture;

    // Only the three legal mux selects can ever be produced here.
    function automatic logic [2:0] opToFxn(input logic [1:0] op);
        case (op)
            2'b01:   return 3'b100;
            2'b10:   return 3'b101;
            default: return 3'b000;
        endcase
    endfunction

    assign cmd_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign capture   = (state == EXEC) && (latCnt == 4'd0);

    always_comb begin
        stateNext   = state;
        latCntNext  = latCnt;
        aluANext    = alu_a;
        aluBNext    = alu_b;
        aluFxnNext  = alu_fxn;
        rspDataNext = rsp_data;
        rspErrNext  = rsp_err;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    if (cmd_op == 2'b11) begin
                        rspDataNext = '0;
                        rspErrNext  = 1'b1;
                        stateNext   = RESP;
                    end else begin
                        aluANext   = cmd_a;
                        aluBNext   = cmd_b;
                        aluFxnNext = opToFxn(cmd_op);
                        latCntNext = 4'(ALU_LAT - 1);
                        stateNext  = EXEC;
                    end
                end
            end
            EXEC: begin
                if (capture) begin
                    rspDataNext = alu_result;
                    rspErrNext  = 1'b0;
                    aluFxnNext  = 3'b000;
                    stateNext   = RESP;
                end else begin
                    latCntNext = latCnt - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            latCnt   <= 4'd0;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_fxn  <= 3'b000;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
        end else begin
            state    <= stateNext;
            latCnt   <= latCntNext;
            alu_a    <= aluANext;
            alu_b    <= aluBNext;
            alu_fxn  <= aluFxnNext;
            rsp_data <= rspDataNext;
            rsp_err  <= rspErrNext;
        end
    end

`ifdef ALU_SEQ_CHECK_EN
    logic [DW-1:0] expResult;

    // Expected value is recomputed from the operands still held on the datapath.
    always_comb begin
        case (alu_fxn)
            3'b100:  expResult = {{(DW-1){1'b0}}, (alu_a < alu_b)};
            3'b101:  expResult = ~(alu_a ^ alu_b);
            default: expResult = alu_a + alu_b;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chk_mismatch <= 1'b0;
        end else if (capture && (expResult != alu_result)) begin
            chk_mismatch <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomized and directed checks of alu_op_sequencer against an arithmetic reference model.
module tb_alu_op_sequencer;
    localparam int DW  = 6;
    localparam int LAT = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_err;
    logic [1:0]    cmd_op;
    logic [DW-1:0] cmd_a, cmd_b, alu_a, alu_b, alu_result, rsp_data;
    logic [2:0]    alu_fxn;
`ifdef ALU_SEQ_CHECK_EN
    logic          chk_mismatch;
`endif

    int total = 0;
    int bad   = 0;
    logic [DW-1:0] lastA, lastB;

    always #5 clk = ~clk;

    alu_op_sequencer #(.DW(DW), .ALU_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_fxn(alu_fxn), .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err)
`ifdef ALU_SEQ_CHECK_EN
        , .chk_mismatch(chk_mismatch)
`endif
    );

    // Mini-ALU datapath behind the function-select mux; illegal selects give junk.
    always_comb begin
        case (alu_fxn)
            3'b000:  alu_result = alu_a + alu_b;
            3'b100:  alu_result = (alu_a < alu_b) ? 6'd1 : 6'd0;
            3'b101:  alu_result = ~(alu_a ^ alu_b);
            default: alu_result = 6'h2A;
        endcase
    end

    // Reference: {err, data} from the op rules in plain integer arithmetic.
    function automatic logic [6:0] refModel(input int op, input int a, input int b);
        int r;
        case (op)
            0:       r = (a + b) % 64;
            1:       r = (a < b) ? 1 : 0;
            2:       r = 63 - (a ^ b);
            default: return 7'h40;
        endcase
        return {1'b0, 6'(r)};
    endfunction

    function automatic logic [2:0] refFxn(input int op);
        if (op == 1) return 3'b100;
        if (op == 2) return 3'b101;
        return 3'b000;
    endfunction

    // Drives one command and reports what was observed; callers do the judging.
    task automatic runCmd(input logic [1:0] op, input logic [5:0] a, input logic [5:0] b,
                          input int hold, output int lat, output logic [5:0] data,
                          output logic err, output logic [2:0] fxn, output logic [5:0] sa,
                          output logic [5:0] sb, output logic stableOk,
                          output logic readyLowOk, output logic postOk);
        int k;
        stableOk = 1'b1; readyLowOk = 1'b1; postOk = 1'b0; lat = -2;
        data = '0; err = 1'b0; fxn = '0; sa = '0; sb = '0;
        k = 0;
        while (cmd_ready !== 1'b1 && k < 50) begin @(negedge clk); k++; end
        if (cmd_ready !== 1'b1) return;
        cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0; cmd_op = 2'($urandom); cmd_a = 6'($urandom); cmd_b = 6'($urandom);
        fxn = alu_fxn; sa = alu_a; sb = alu_b;
        k = 1;
        while (rsp_valid !== 1'b1 && k < 50) begin
            if (cmd_ready !== 1'b0) readyLowOk = 1'b0;
            @(negedge clk);
            k++;
        end
        lat  = (rsp_valid === 1'b1) ? k : -1;
        data = rsp_data;
        err  = rsp_err;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_data !== data || rsp_err !== err || cmd_ready !== 1'b0)
                stableOk = 1'b0;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        postOk = (rsp_valid === 1'b0) && (cmd_ready === 1'b1) && (alu_fxn === 3'b000);
    endtask

    task automatic test_reset();
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready got=%b want=1", cmd_ready); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
        total++; if (rsp_data !== 6'd0 || rsp_err !== 1'b0) begin bad++; $display("FAIL reset_rsp got=%0d/%b want=0/0", rsp_data, rsp_err); end
        total++; if (alu_a !== 6'd0 || alu_b !== 6'd0 || alu_fxn !== 3'b000) begin bad++; $display("FAIL reset_alu got=%0d/%0d/%b want=0/0/000", alu_a, alu_b, alu_fxn); end
        rst = 1'b0;
        @(negedge clk); @(negedge clk);
        total++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin bad++; $display("FAIL idle_after_reset got=%b/%b want=1/0", cmd_ready, rsp_valid); end
        lastA = '0; lastB = '0;
    endtask

    task automatic test_add();
        logic [5:0] ta[2] = '{6'd20, 6'd40};
        logic [5:0] tb[2] = '{6'd30, 6'd30};
        logic [5:0] te[2] = '{6'd50, 6'd6};
        int lat; logic [5:0] d, sa, sb; logic e, sOk, rOk, pOk; logic [2:0] f;
        for (int i = 0; i < 2; i++) begin
            runCmd(2'b00, ta[i], tb[i], 0, lat, d, e, f, sa, sb, sOk, rOk, pOk);
            total++; if (lat !== LAT + 1) begin bad++; $display("FAIL add_latency[%0d] got=%0d want=%0d", i, lat, LAT + 1); end
            total++; if (d !== te[i] || e !== 1'b0) begin bad++; $display("FAIL add_data[%0d] got=%0d/%b want=%0d/0", i, d, e, te[i]); end
            total++; if (f !== 3'b000 || sa !== ta[i] || sb !== tb[i]) begin bad++; $display("FAIL add_drive[%0d] got=%b/%0d/%0d want=000/%0d/%0d", i, f, sa, sb, ta[i], tb[i]); end
            total++; if (rOk !== 1'b1 || pOk !== 1'b1) begin bad++; $display("FAIL add_handshake[%0d] got=%b/%b want=1/1", i, rOk, pOk); end
            lastA = ta[i]; lastB = tb[i];
        end
    endtask

    task automatic test_lt();
        logic [5:0] ta[2] = '{6'd5, 6'd9};
        logic [5:0] tb[2] = '{6'd9, 6'd5};
        logic [5:0] te[2] = '{6'd1, 6'd0};
        int lat; logic [5:0] d, sa, sb; logic e, sOk, rOk, pOk; logic [2:0] f;
        for (int i = 0; i < 2; i++) begin
            runCmd(2'b01, ta[i], tb[i], 0, lat, d, e, f, sa, sb, sOk, rOk, pOk);
            total++; if (lat !== LAT + 1) begin bad++; $display("FAIL lt_latency[%0d] got=%0d want=%0d", i, lat, LAT + 1); end
            total++; if (d !== te[i] || e !== 1'b0) begin bad++; $display("FAIL lt_data[%0d] got=%0d/%b want=%0d/0", i, d, e, te[i]); end
            total++; if (f !== 3'b100) begin bad++; $display("FAIL lt_fxn[%0d] got=%b want=100", i, f); end
            lastA = ta[i]; lastB = tb[i];
        end
    endtask

    task automatic test_xnor_backpressure();
        int lat; logic [5:0] d, sa, sb; logic e, sOk, rOk, pOk; logic [2:0] f;
        runCmd(2'b10, 6'b101010, 6'b110011, 5, lat, d, e, f, sa, sb, sOk, rOk, pOk);
        total++; if (d !== 6'b100110 || e !== 1'b0) begin bad++; $display("FAIL xnor_data got=%b/%b want=100110/0", d, e); end
        total++; if (f !== 3'b101) begin bad++; $display("FAIL xnor_fxn got=%b want=101", f); end
        total++; if (sOk !== 1'b1) begin bad++; $display("FAIL xnor_hold_stable got=%b want=1", sOk); end
        total++; if (pOk !== 1'b1) begin bad++; $display("FAIL xnor_release got=%b want=1", pOk); end
        runCmd(2'b00, 6'd7, 6'd8, 0, lat, d, e, f, sa, sb, sOk, rOk, pOk);
        total++; if (lat !== LAT + 1 || d !== 6'd15) begin bad++; $display("FAIL after_hold_cmd got=%0d/%0d want=%0d/15", lat, d, LAT + 1); end
        lastA = 6'd7; lastB = 6'd8;
    endtask

    task automatic test_reserved();
        int lat; logic [5:0] d, sa, sb; logic e, sOk, rOk, pOk; logic [2:0] f;
        runCmd(2'b11, 6'd12, 6'd34, 2, lat, d, e, f, sa, sb, sOk, rOk, pOk);
        total++; if (lat !== 1) begin bad++; $display("FAIL rsv_latency got=%0d want=1", lat); end
        total++; if (d !== 6'd0 || e !== 1'b1) begin bad++; $display("FAIL rsv_resp got=%0d/%b want=0/1", d, e); end
        total++; if (f !== 3'b000 || sa !== lastA || sb !== lastB) begin bad++; $display("FAIL rsv_alu_untouched got=%b/%0d/%0d want=000/%0d/%0d", f, sa, sb, lastA, lastB); end
        total++; if (sOk !== 1'b1 || pOk !== 1'b1) begin bad++; $display("FAIL rsv_handshake got=%b/%b want=1/1", sOk, pOk); end
    endtask

    task automatic test_back_to_back();
        int k; logic [5:0] d1;
        d1 = 6'h3F;
        k = 0;
        while (cmd_ready !== 1'b1 && k < 50) begin @(negedge clk); k++; end
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_a = 6'd3; cmd_b = 6'd7; rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_op = 2'b10; cmd_a = 6'd0; cmd_b = 6'd0;
        k = 1;
        while (cmd_ready !== 1'b1 && k < 50) begin
            if (rsp_valid === 1'b1) d1 = rsp_data;
            @(negedge clk);
            k++;
        end
        total++; if (k !== LAT + 2) begin bad++; $display("FAIL b2b_spacing got=%0d want=%0d", k, LAT + 2); end
        total++; if (d1 !== 6'd1) begin bad++; $display("FAIL b2b_first_data got=%0d want=1", d1); end
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        k = 1;
        while (rsp_valid !== 1'b1 && k < 50) begin @(negedge clk); k++; end
        total++; if (k !== LAT + 1 || rsp_data !== 6'd63 || rsp_err !== 1'b0) begin bad++; $display("FAIL b2b_second got=%0d/%0d/%b want=%0d/63/0", k, rsp_data, rsp_err, LAT + 1); end
        @(negedge clk);
        rsp_ready = 1'b0;
        lastA = 6'd0; lastB = 6'd0;
    endtask

    task automatic test_abort();
        int k; int lat; logic [5:0] d, sa, sb; logic e, sOk, rOk, pOk; logic [2:0] f; logic seen;
        k = 0;
        while (cmd_ready !== 1'b1 && k < 50) begin @(negedge clk); k++; end
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_a = 6'd10; cmd_b = 6'd11;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        total++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin bad++; $display("FAIL abort_ctrl got=%b/%b want=1/0", cmd_ready, rsp_valid); end
        total++; if (alu_a !== 6'd0 || alu_b !== 6'd0 || alu_fxn !== 3'b000 || rsp_data !== 6'd0 || rsp_err !== 1'b0) begin bad++; $display("FAIL abort_outputs got=%0d/%0d/%b/%0d/%b want=0/0/000/0/0", alu_a, alu_b, alu_fxn, rsp_data, rsp_err); end
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin @(negedge clk); if (rsp_valid !== 1'b0) seen = 1'b1; end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL abort_no_response got=%b want=0", seen); end
        runCmd(2'b00, 6'd1, 6'd1, 0, lat, d, e, f, sa, sb, sOk, rOk, pOk);
        total++; if (lat !== LAT + 1 || d !== 6'd2) begin bad++; $display("FAIL abort_recover got=%0d/%0d want=%0d/2", lat, d, LAT + 1); end
        lastA = 6'd1; lastB = 6'd1;
    endtask

    task automatic test_random();
        int lat; logic [5:0] d, sa, sb, a, b; logic e, sOk, rOk, pOk; logic [2:0] f;
        logic [1:0] op; logic [6:0] exp;
        for (int n = 0; n < 40; n++) begin
            op = 2'($urandom); a = 6'($urandom); b = 6'($urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            exp = refModel(int'(op), int'(a), int'(b));
            runCmd(op, a, b, $urandom_range(0, 3), lat, d, e, f, sa, sb, sOk, rOk, pOk);
            total++;
            if (d !== exp[5:0] || e !== exp[6]) begin
                bad++; $display("FAIL rand_resp[%0d] op=%0d a=%0d b=%0d got=%0d/%b want=%0d/%b", n, op, a, b, d, e, exp[5:0], exp[6]);
            end
            total++;
            if (lat !== ((op == 2'b11) ? 1 : LAT + 1)) begin
                bad++; $display("FAIL rand_latency[%0d] op=%0d got=%0d", n, op, lat);
            end
            total++;
            if (f !== refFxn(int'(op)) || sa !== ((op == 2'b11) ? lastA : a) || sb !== ((op == 2'b11) ? lastB : b)) begin
                bad++; $display("FAIL rand_drive[%0d] op=%0d got=%b/%0d/%0d", n, op, f, sa, sb);
            end
            total++;
            if (sOk !== 1'b1 || rOk !== 1'b1 || pOk !== 1'b1) begin
                bad++; $display("FAIL rand_flow[%0d] got=%b/%b/%b want=1/1/1", n, sOk, rOk, pOk);
            end
            if (op != 2'b11) begin lastA = a; lastB = b; end
        end
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; rsp_ready = 1'b0;
        lastA = '0; lastB = '0;
        @(negedge clk); @(negedge clk);
        test_reset();
        test_add();
        test_lt();
        test_xnor_backpressure();
        test_reserved();
        test_back_to_back();
        test_random();
        test_abort();
`ifdef ALU_SEQ_CHECK_EN
        total++; if (chk_mismatch !== 1'b0) begin bad++; $display("FAIL chk_mismatch got=%b want=0", chk_mismatch); end
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
